mont_exp_ctrl: RTL and testbench

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

---
 rtl/mont_exp_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Montgomery modular exponentiation controller.
// Left-to-right square-and-multiply over an external Montgomery multiplier.
// ACC starts at R mod M; for each exponent bit (MSB first) ACC = Mont(ACC,ACC),
// then ACC = Mont(ACC,X) when the bit is set.
// Build option: define MONT_EXP_FROMMONT_EN to add a final Mont(ACC,1) step
// that converts the result out of Montgomery form.
module mont_exp_ctrl (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [1023:0] in_x,
    input  logic [1023:0] in_r,
    input  logic [1023:0] in_m,
    input  logic [1023:0] in_e,
    input  logic [10:0]   in_e_len,
    output logic [1023:0] result,
    output logic          done,
    output logic          busy,
    output logic          mont_start,
    output logic [1023:0] mont_a,
    output logic [1023:0] mont_b,
    output logic [1023:0] mont_m,
    input  logic [1023:0] mont_result,
    input  logic          mont_done
);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
`ifdef MONT_EXP_FROMMONT_EN
        CONV_ISSUE,
        CONV_WAIT,
`endif
        FIN
    } state_t;

    // Where the walk goes once every exponent bit has been consumed.
`ifdef MONT_EXP_FROMMONT_EN
    localparam state_t BITS_DONE = CONV_ISSUE;
`else
    localparam state_t BITS_DONE = FIN;
`endif

    state_t         state, state_d;
    logic [1023:0]  acc;
    logic [1023:0]  x_q, m_q, e_q;
    logic [9:0]     idx;
    logic [10:0]    len_c;
    logic           accept, acc_ld, dec, issue_d;

    // Exponent lengths above 1024 are treated as 1024.
    assign len_c = (in_e_len > 11'd1024) ? 11'd1024 : in_e_len;

    assign busy   = (state != IDLE);
    assign mont_a = acc;
    assign mont_m = m_q;

    // Operand B follows the operation in flight; ACC only changes on mont_done,
    // so both operands stay stable from ISSUE until the product returns.
    always_comb begin
        mont_b = acc;
        case (state)
            MUL_ISSUE, MUL_WAIT:   mont_b = x_q;
`ifdef MONT_EXP_FROMMONT_EN
            CONV_ISSUE, CONV_WAIT: mont_b = 1024'd1;
`endif
            default:               mont_b = acc;
        endcase
    end

    // Next-state logic plus the ACC-load and bit-index-decrement strobes.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        acc_ld  = 1'b0;
        dec     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_c != 11'd0) ? SQ_ISSUE : BITS_DONE;
                end
            end
            SQ_ISSUE:  state_d = SQ_WAIT;
            SQ_WAIT: begin
                if (mont_done) begin
                    acc_ld = 1'b1;
                    if (e_q[idx]) begin
                        state_d = MUL_ISSUE;
                    end else begin
                        dec     = (idx != 10'd0);
                        state_d = (idx != 10'd0) ? SQ_ISSUE : BITS_DONE;
                    end
                end
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mont_done) begin
                    acc_ld  = 1'b1;
                    dec     = (idx != 10'd0);
                    state_d = (idx != 10'd0) ? SQ_ISSUE : BITS_DONE;
                end
            end
`ifdef MONT_EXP_FROMMONT_EN
            CONV_ISSUE: state_d = CONV_WAIT;
            CONV_WAIT: begin
                if (mont_done) begin
                    acc_ld  = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // mont_start is registered so it is high exactly while in an ISSUE state.
    always_comb begin
        issue_d = (state_d == SQ_ISSUE) || (state_d == MUL_ISSUE);
`ifdef MONT_EXP_FROMMONT_EN
        if (state_d == CONV_ISSUE) issue_d = 1'b1;
`endif
    end

    // Control state, accumulator, bit index and result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            result     <= '0;
            done       <= 1'b0;
            mont_start <= 1'b0;
        end else begin
            state      <= state_d;
            mont_start <= issue_d;
            done       <= (state == FIN);
            if (accept) begin
                acc <= in_r;
                idx <= 10'(len_c - 11'd1);
            end
            if (acc_ld)         acc    <= mont_result;
            if (dec)            idx    <= idx - 10'd1;
            if (state == FIN)   result <= acc;
        end
    end

    // Operands captured at accept; later input changes do not disturb a run.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= in_x;
            m_q <= in_m;
            e_q <= in_e;
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with random
// latency, directed scenarios with hand-computed results for M = 13.
// R = 2^1024 mod 13 = 3, R^-1 mod 13 = 9, so Mont(a,b) = a*b*9 mod 13.
// Base x = 2 in normal form, X = 6 in Montgomery form.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;

`ifdef MONT_EXP_FROMMONT_EN
    localparam int            EXTRA = 1;
    localparam logic [1023:0] R_E11 = 1024'd7;   // 2^11 mod 13
    localparam logic [1023:0] R_E3  = 1024'd8;   // 2^3 mod 13 (also 2^(2^1024-1))
    localparam logic [1023:0] R_E0  = 1024'd1;
`else
    localparam int            EXTRA = 0;
    localparam logic [1023:0] R_E11 = 1024'd8;   // 7*R mod 13
    localparam logic [1023:0] R_E3  = 1024'd11;  // 8*R mod 13
    localparam logic [1023:0] R_E0  = 1024'd3;   // in_r
`endif

    logic          clk = 1'b0;
    logic          resetn, start;
    logic [1023:0] in_x, in_r, in_m, in_e;
    logic [10:0]   in_e_len;
    logic [1023:0] result, mont_a, mont_b, mont_m, mont_result;
    logic          done, busy, mont_start, mont_done;

    logic          done_r = 1'b0, inj_done = 1'b0;
    logic [1023:0] res_r = '0, inj_res = '0;
    assign mont_done   = done_r | inj_done;
    assign mont_result = inj_done ? inj_res : res_r;

    int checks = 0, failures = 0;
    int lat_max = 40;
    int n_pulses = 0, done_cnt = 0, unstable = 0;
    logic [63:0] log_a[$], log_b[$];
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [1023:0] cap_a, cap_b;

    always #5 clk = ~clk;

    mont_exp_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_e_len(in_e_len),
        .result(result), .done(done), .busy(busy),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    function automatic logic [63:0] mont13(input logic [63:0] a, input logic [63:0] b);
        return (((a % 13) * (b % 13)) % 13) * 9 % 13;
    endfunction

    // Behavioural multiplier: logs each request, checks operand stability,
    // answers after 3..lat_max cycles. Reset discards the request in flight.
    always @(negedge clk) begin
        if (!resetn) begin
            pend   = 1'b0;
            done_r = 1'b0;
        end else begin
            if (done_r) done_r = 1'b0;
            if (done) done_cnt++;
            if (mont_start) begin
                n_pulses++;
                log_a.push_back(mont_a[63:0]);
                log_b.push_back(mont_b[63:0]);
                cap_a = mont_a;
                cap_b = mont_b;
                if (mont_m !== 1024'd13) unstable++;
                pend = 1'b1;
                cnt  = $urandom_range(lat_max, 3);
            end else if (pend) begin
                if (mont_a !== cap_a || mont_b !== cap_b || mont_m !== 1024'd13) unstable++;
                cnt--;
                if (cnt == 0) begin
                    res_r  = {960'd0, mont13(cap_a[63:0], cap_b[63:0])};
                    done_r = 1'b1;
                    pend   = 1'b0;
                end
            end
        end
    end

    task automatic clear_log();
        n_pulses = 0;
        unstable = 0;
        log_a.delete();
        log_b.delete();
    endtask

    task automatic kick(input logic [1023:0] x, input logic [1023:0] r,
                        input logic [1023:0] e, input logic [10:0] len);
        @(negedge clk);
        in_x = x; in_r = r; in_m = 1024'd13; in_e = e; in_e_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_e_len = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (mont_start !== 1'b0) begin failures++; $display("FAIL rst_mont_start got=%0b exp=0", mont_start); end
        checks++; if (result !== '0)       begin failures++; $display("FAIL rst_result got=%0h exp=0", result[63:0]); end
        @(negedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_exp11();
        bit ok;
        string ops;
        int err;
        logic [63:0] acc_m, eb;
        ops = (EXTRA != 0) ? "SMSSMSMC" : "SMSSMSM";
        lat_max = 40;
        clear_log();
        kick(1024'd6, 1024'd3, 1024'hB, 11'd4);
        // Inputs scrambled after accept must not influence the run.
        in_x = '1; in_r = 1024'd5; in_m = 1024'd7; in_e = '0; in_e_len = 11'd1;
        wait_done(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL e11_timeout got=no_done exp=done"); end
        checks++; if (n_pulses != 7 + EXTRA) begin failures++; $display("FAIL e11_pulses got=%0d exp=%0d", n_pulses, 7 + EXTRA); end
        err = 0;
        acc_m = 64'd3;
        for (int i = 0; i < log_a.size() && i < ops.len(); i++) begin
            eb = (ops[i] == "S") ? acc_m : (ops[i] == "M") ? 64'd6 : 64'd1;
            if (log_a[i] !== acc_m || log_b[i] !== eb) err++;
            acc_m = mont13(acc_m, eb);
        end
        checks++; if (err != 0) begin failures++; $display("FAIL e11_op_order got=%0d_bad exp=0_bad", err); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL e11_operand_stable got=%0d exp=0", unstable); end
        checks++; if (result !== R_E11) begin failures++; $display("FAIL e11_result got=%0h exp=%0h", result[63:0], R_E11[63:0]); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL e11_done_pulse got=%0b%0b exp=00", done, busy); end
        in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_e_len = '0;
    endtask

    task automatic test_elen0();
        bit ok;
        lat_max = 40;
        clear_log();
        kick(1024'd6, 1024'd3, 1024'h5, 11'd0);
`ifdef MONT_EXP_FROMMONT_EN
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL e0_timeout got=no_done exp=done"); end
        checks++; if (n_pulses != 1) begin failures++; $display("FAIL e0_pulses got=%0d exp=1", n_pulses); end
`else
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL e0_done_early got=%0b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL e0_done_timing got=%0b exp=1", done); end
        checks++; if (n_pulses != 0) begin failures++; $display("FAIL e0_pulses got=%0d exp=0", n_pulses); end
`endif
        checks++; if (result !== R_E0) begin failures++; $display("FAIL e0_result got=%0h exp=%0h", result[63:0], R_E0[63:0]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        lat_max = 40;
        clear_log();
        @(negedge clk);
        in_x = 1024'd6; in_r = 1024'd3; in_m = 1024'd13; in_e = 1024'h3; in_e_len = 11'd2;
        start = 1'b1;
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout1 got=no_done exp=done"); end
        checks++; if (result !== R_E3) begin failures++; $display("FAIL b2b_result1 got=%0h exp=%0h", result[63:0], R_E3[63:0]); end
        checks++; if (n_pulses != 4 + EXTRA) begin failures++; $display("FAIL b2b_pulses1 got=%0d exp=%0d", n_pulses, 4 + EXTRA); end
        clear_log();
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_restart got=busy%0b_done%0b exp=busy1_done0", busy, done); end
        wait_done(2000, ok);
        start = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout2 got=no_done exp=done"); end
        checks++; if (result !== R_E3) begin failures++; $display("FAIL b2b_result2 got=%0h exp=%0h", result[63:0], R_E3[63:0]); end
        checks++; if (n_pulses != 4 + EXTRA) begin failures++; $display("FAIL b2b_pulses2 got=%0d exp=%0d", n_pulses, 4 + EXTRA); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dc;
        lat_max = 40;
        clear_log();
        kick(1024'd6, 1024'd3, 1024'hB, 11'd4);
        // Third request is the second squaring (S,M,S).
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_pulses == 3) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL rmid_reach got=%0d_pulses exp=3", n_pulses); end
        @(posedge clk); #2;
        resetn = 1'b0;
        dc = done_cnt;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || mont_start !== 1'b0) begin failures++; $display("FAIL rmid_abort got=busy%0b_ms%0b exp=busy0_ms0", busy, mont_start); end
        checks++; if (result !== '0) begin failures++; $display("FAIL rmid_result_clr got=%0h exp=0", result[63:0]); end
        @(negedge clk); #1 resetn = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (done_cnt != dc || n_pulses != 3) begin failures++; $display("FAIL rmid_quiet got=done%0d_pulses%0d exp=done%0d_pulses3", done_cnt, n_pulses, dc); end
        clear_log();
        kick(1024'd6, 1024'd3, 1024'h3, 11'd2);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=no_done exp=done"); end
        checks++; if (result !== R_E3) begin failures++; $display("FAIL rmid_result got=%0h exp=%0h", result[63:0], R_E3[63:0]); end
        checks++; if (n_pulses != 4 + EXTRA) begin failures++; $display("FAIL rmid_pulses got=%0d exp=%0d", n_pulses, 4 + EXTRA); end
    endtask

    task automatic test_spurious_done();
        bit ok;
        logic [1023:0] prev;
        lat_max = 40;
        prev = result;
        @(negedge clk);
        inj_res = 1024'd5; inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        checks++; if (busy !== 1'b0 || mont_start !== 1'b0 || result !== prev) begin failures++; $display("FAIL spur_idle got=busy%0b_res%0h exp=busy0_res%0h", busy, result[63:0], prev[63:0]); end
        clear_log();
        kick(1024'd6, 1024'd3, 1024'hB, 11'd4);
        // Now in SQ_ISSUE: a stray completion with a junk product must be ignored.
        inj_res = 1024'd5; inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        wait_done(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL spur_timeout got=no_done exp=done"); end
        checks++; if (result !== R_E11) begin failures++; $display("FAIL spur_result got=%0h exp=%0h", result[63:0], R_E11[63:0]); end
        checks++; if (n_pulses != 7 + EXTRA) begin failures++; $display("FAIL spur_pulses got=%0d exp=%0d", n_pulses, 7 + EXTRA); end
    endtask

    task automatic test_full_len();
        bit ok;
        logic [10:0] lens [2];
        lens[0] = 11'd1024;
        lens[1] = 11'd2000;
        lat_max = 4;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            kick(1024'd6, 1024'd3, '1, lens[k]);
            wait_done(20000, ok);
            checks++; if (!ok) begin failures++; $display("FAIL full%0d_timeout got=no_done exp=done", lens[k]); end
            checks++; if (n_pulses != 2048 + EXTRA) begin failures++; $display("FAIL full%0d_pulses got=%0d exp=%0d", lens[k], n_pulses, 2048 + EXTRA); end
            checks++; if (result !== R_E3) begin failures++; $display("FAIL full%0d_result got=%0h exp=%0h", lens[k], result[63:0], R_E3[63:0]); end
        end
        lat_max = 40;
    endtask

    initial begin
        test_reset();
        test_exp11();
        test_elen0();
        test_back_to_back();
        test_reset_mid();
        test_spurious_done();
        test_full_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
